input_mems_pingpong: RTL
========================

// Module: input_mems_pingpong
// PURPOSE
//   Double-buffered (ping-pong) successor of the matmul input memory. Accepts A (MxK) and B (KxN)
//   matrices over AXI-Stream into one of two banks while the compute unit reads the other bank,
//   so the next load overlaps the current compute. Supports reuse of the last loaded A (new_A=0).
//   Sits between the AXIS input port and the MAC array's A/B read ports.
// PARAMETERS
//   INW   12  data word width (signed)
//   M      7  rows of A
//   N      9  columns of B
//   MAXK   8  max inner dimension K; K_BITS=$clog2(MAXK+1), A_ADDR_BITS=$clog2(M*MAXK), B_ADDR_BITS=$clog2(MAXK*N)
// PORTS
//   clk               in   1            clock, all logic on rising edge
//   reset             in   1            asynchronous, active-high reset
//   AXIS_TDATA        in   INW          stream data word
//   AXIS_TVALID       in   1            stream valid
//   AXIS_TUSER        in   K_BITS+1     [0]=new_A, [K_BITS:1]=K; sampled on first beat of a load only
//   AXIS_TREADY       out  1            stream ready
//   matrices_loaded   out  1            read bank holds a complete A/B pair
//   compute_finished  in   1            1-cycle pulse: compute done with read bank
//   K                 out  K_BITS       K of read bank
//   A_read_addr       in   A_ADDR_BITS  A element address (row-major, addr = r*K + c)
//   A_data            out  INW          A word, signed
//   B_read_addr       in   B_ADDR_BITS  B element address (row-major, addr = r*N + c)
//   B_data            out  INW          B word, signed
// BEHAVIOUR
//   Storage: banks 0/1, each with A store (M*MAXK words), B store (MAXK*N words), K reg, a_src bit.
//   Pointers: wr_bank, rd_bank, full[1:0], last_a (A store holding newest A). Reset: all 0, banks empty.
//   Reset outputs: AXIS_TREADY=0 while reset high; matrices_loaded=0, K=0, A_data=0, B_data=0.
//   Loader FSM: IDLE -> LOAD_A -> LOAD_B -> IDLE. Beat = TVALID&TREADY; TVALID low stalls, no state change.
//   IDLE: TREADY = !full[wr_bank] && !hazard. First beat latches K, new_A into bank wr_bank.
//     new_A=1: word -> A[wr_bank][0], a_src[wr]=wr, last_a=wr, go LOAD_A (counter=1).
//     new_A=0: word -> B[wr_bank][0], a_src[wr]=last_a, go LOAD_B (counter=1).
//   hazard = TVALID && new_A && full[~wr_bank] && a_src[~wr_bank]==wr_bank (would overwrite A in use).
//   LOAD_A: TREADY=1; beat writes A[wr][counter]; after beat M*K (index M*K-1) go LOAD_B, counter=0.
//   LOAD_B: TREADY=1; beat writes B[wr][counter]; on beat K*N (index K*N-1): full[wr]=1,
//     wr_bank toggles, go IDLE. TUSER ignored in LOAD_A/LOAD_B.
//   Reads: A_data <= A[a_src[rd_bank]][A_read_addr], B_data <= B[rd_bank][B_read_addr];
//     1-cycle latency, registered, valid regardless of matrices_loaded (contents undefined if empty).
//   matrices_loaded = full[rd_bank] (registered state, high the cycle after last B beat).
//   K output = K reg of rd_bank. compute_finished while full[rd_bank]: full[rd]=0, rd_bank toggles
//     next cycle; ignored when matrices_loaded=0.
//   Simultaneous last-B-beat and compute_finished: both take effect same edge (different banks).
//   Both banks full: TREADY=0 in IDLE until a compute_finished frees a bank.
//   new_A=0 before any A loaded since reset: uses A store 0 (undefined contents); not flagged.
//   K outside 1..MAXK is unsupported and not checked. Counters sized for M*MAXK and MAXK*N, no wrap.
//   reset mid-load: partial load discarded, both banks empty, FSM IDLE, last_a=0.
// TESTING
//   1 Reset, new_A=1 K=3, 21 A beats (A[i]=i) + 27 B beats (B[i]=100+i) -> TREADY held 1,
//     matrices_loaded=1 cycle after beat 48, K=3, A_read_addr=5 -> A_data=5 next cycle, B addr 26 -> 126.
//   2 Load two pairs back-to-back, no compute_finished -> third load sees TREADY=0; pulse
//     compute_finished -> TREADY=1 next cycle, K switches to second load's K.
//   3 new_A=1 K=2 then new_A=0 K=2 with 18 B beats -> second bank reads return first A, new B.
//   4 Hazard: bank1 reuses A in bank0; free bank0, offer new_A=1 first beat -> TREADY=0 until
//     bank1 compute_finished, then accepted; bank1 reads unchanged during stall.
//   5 Random TVALID gaps (50%) during load -> identical memory contents to test 1, beat count exact.
//   6 Assert reset after 10 A beats -> matrices_loaded=0, TREADY=0 during reset; fresh load after
//     release completes correctly with K from new first beat.

Source files
------------

// File: rtl/input_mems_pingpong.sv
`default_nettype none
// ============================================================================
// Module   : input_mems_pingpong
// Brief    : Ping-pong A/B input memory for the MAC array, AXI-Stream loaded.
// Revision : 1.0 - initial release
// ============================================================================
module input_mems_pingpong #(
    parameter int INW         = 12,
    parameter int M           = 7,
    parameter int N           = 9,
    parameter int MAXK        = 8,
    parameter int K_BITS      = $clog2(MAXK + 1),
    parameter int A_ADDR_BITS = $clog2(M * MAXK),
    parameter int B_ADDR_BITS = $clog2(MAXK * N)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [INW-1:0]         AXIS_TDATA,
    input  logic                   AXIS_TVALID,
    input  logic [K_BITS:0]        AXIS_TUSER,
    output logic                   AXIS_TREADY,
    output logic                   matrices_loaded,
    input  logic                   compute_finished,
    output logic [K_BITS-1:0]      K,
    input  logic [A_ADDR_BITS-1:0] A_read_addr,
    output logic [INW-1:0]         A_data,
    input  logic [B_ADDR_BITS-1:0] B_read_addr,
    output logic [INW-1:0]         B_data
);

    localparam int c_A_WORDS  = M * MAXK;
    localparam int c_B_WORDS  = MAXK * N;
    localparam int c_CNT_BITS = $clog2(((M > N) ? M : N) * MAXK + 1);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_LOAD_A = 2'd1;
    localparam logic [1:0] c_LOAD_B = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_state_next;
    logic [c_CNT_BITS-1:0] r_cnt;
    logic                  r_wr_bank;
    logic                  r_rd_bank;
    logic                  r_last_a;
    logic [1:0]            r_full;
    logic [1:0]            w_full_next;
    logic [1:0]            r_a_src;
    logic [K_BITS-1:0]     r_k [2];

    logic [INW-1:0] r_a_mem [2][c_A_WORDS];
    logic [INW-1:0] r_b_mem [2][c_B_WORDS];

    logic                   w_beat;
    logic                   w_other;
    logic                   w_hazard;
    logic [K_BITS-1:0]      w_k_wr;
    logic [c_CNT_BITS-1:0]  w_a_last;
    logic [c_CNT_BITS-1:0]  w_b_last;
    logic                   w_a_we;
    logic                   w_b_we;
    logic [A_ADDR_BITS-1:0] w_a_waddr;
    logic [B_ADDR_BITS-1:0] w_b_waddr;
    logic                   w_load_done;
    logic                   w_free;

    assign w_beat   = AXIS_TVALID && AXIS_TREADY;
    assign w_other  = ~r_wr_bank;
    // A new A would clobber the A store the other (full) bank is still reading
    assign w_hazard = AXIS_TVALID && AXIS_TUSER[0] && r_full[w_other]
                      && (r_a_src[w_other] == r_wr_bank);
    assign w_k_wr   = r_k[r_wr_bank];
    assign w_a_last = c_CNT_BITS'(M) * c_CNT_BITS'(w_k_wr) - c_CNT_BITS'(1);
    assign w_b_last = c_CNT_BITS'(w_k_wr) * c_CNT_BITS'(N) - c_CNT_BITS'(1);

    assign w_a_we    = w_beat && (((r_state == c_IDLE) && AXIS_TUSER[0]) || (r_state == c_LOAD_A));
    assign w_b_we    = w_beat && (((r_state == c_IDLE) && !AXIS_TUSER[0]) || (r_state == c_LOAD_B));
    assign w_a_waddr = (r_state == c_IDLE) ? '0 : r_cnt[A_ADDR_BITS-1:0];
    assign w_b_waddr = (r_state == c_IDLE) ? '0 : r_cnt[B_ADDR_BITS-1:0];

    assign w_load_done = w_beat && (r_state == c_LOAD_B) && (r_cnt == w_b_last);
    assign w_free      = compute_finished && r_full[r_rd_bank];

    assign matrices_loaded = r_full[r_rd_bank];
    assign K               = r_k[r_rd_bank];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= c_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:   if (w_beat) w_state_next = AXIS_TUSER[0] ? c_LOAD_A : c_LOAD_B;
            c_LOAD_A: if (w_beat && (r_cnt == w_a_last)) w_state_next = c_LOAD_B;
            c_LOAD_B: if (w_load_done) w_state_next = c_IDLE;
            default:  w_state_next = c_IDLE;
        endcase
    end

    always_comb begin
        AXIS_TREADY = 1'b0;
        case (r_state)
            c_IDLE:             AXIS_TREADY = !reset && !r_full[r_wr_bank] && !w_hazard;
            c_LOAD_A, c_LOAD_B: AXIS_TREADY = !reset;
            default:            AXIS_TREADY = 1'b0;
        endcase
    end

    // Load completion and compute release always touch different banks
    always_comb begin
        w_full_next = r_full;
        if (w_load_done) w_full_next[r_wr_bank] = 1'b1;
        if (w_free)      w_full_next[r_rd_bank] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_last_a  <= 1'b0;
            r_full    <= 2'b00;
            r_a_src   <= 2'b00;
            r_k[0]    <= '0;
            r_k[1]    <= '0;
        end else begin
            r_full <= w_full_next;
            if (w_free) r_rd_bank <= ~r_rd_bank;
            if (w_beat) begin
                case (r_state)
                    c_IDLE: begin
                        r_k[r_wr_bank] <= AXIS_TUSER[K_BITS:1];
                        r_cnt          <= c_CNT_BITS'(1);
                        if (AXIS_TUSER[0]) begin
                            r_a_src[r_wr_bank] <= r_wr_bank;
                            r_last_a           <= r_wr_bank;
                        end else begin
                            r_a_src[r_wr_bank] <= r_last_a;
                        end
                    end
                    c_LOAD_A: r_cnt <= (r_cnt == w_a_last) ? '0 : r_cnt + c_CNT_BITS'(1);
                    c_LOAD_B: begin
                        r_cnt <= r_cnt + c_CNT_BITS'(1);
                        if (w_load_done) r_wr_bank <= ~r_wr_bank;
                    end
                    default: r_cnt <= '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_a_we) r_a_mem[r_wr_bank][w_a_waddr] <= AXIS_TDATA;
        if (w_b_we) r_b_mem[r_wr_bank][w_b_waddr] <= AXIS_TDATA;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            A_data <= '0;
            B_data <= '0;
        end else begin
            A_data <= r_a_mem[r_a_src[r_rd_bank]][A_read_addr];
            B_data <= r_b_mem[r_rd_bank][B_read_addr];
        end
    end

endmodule
`default_nettype wire
